// File: rtl/municao_jogador_pkg.sv
// Shared constants for the player munition: VGA blanking limits, playfield
// limits, pixel colours and the shot FSM encoding.
package municao_jogador_pkg;

    localparam int H_MIN    = 96;
    localparam int V_MIN    = 2;
    localparam int Y_LIMITE = 540;

    localparam logic [7:0] COR_CHEIA = 8'hFF;
    localparam logic [7:0] COR_NULA  = 8'h00;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        VOO     = 2'd1,
        RECARGA = 2'd2
    } estado_t;

endpackage

// File: rtl/municao_jogador_borda.sv
// detector_borda: two-flop synchroniser for an asynchronous button followed by
// a registered rising-edge pulse; a held button yields a single pulse.
module detector_borda (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sinal,
    output logic o_pulso
);

    logic r_sync0;
    logic r_sync1;
    logic r_sync2;
    logic r_pulso;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_pulso <= 1'b0;
        end else begin
            r_sync0 <= i_sinal;
            r_sync1 <= r_sync0;
            r_sync2 <= r_sync1;
            r_pulso <= r_sync1 & ~r_sync2;
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/municao_jogador.sv
// Player shot: launched by the fire button from the ship position, climbs one
// pixel per DELAY_MOVIMENTO cycles, pulses acerto on an enemy hit and paints itself.
import municao_jogador_pkg::*;

module municao_jogador #(
    parameter int DELAY_MOVIMENTO = 200000,
    parameter int COOLDOWN        = 25000000,
    parameter int Y_TOPO          = 3,
    parameter int LARGURA_INIMIGO = 40,
    parameter int ALTURA_INIMIGO  = 30,
    parameter int TIRO_W          = 2,
    parameter int TIRO_H          = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_fire,
    input  logic [10:0] posX_jogador,
    input  logic [10:0] posY_jogador,
    input  logic [10:0] posX_inimigo,
    input  logic [10:0] posY_inimigo,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    output logic [10:0] posX_Municao1,
    output logic [10:0] posY_Municao1,
    output logic        tiro_ativo,
    output logic        acerto,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    localparam int PASSO_W   = $clog2(DELAY_MOVIMENTO + 1);
    localparam int RECARGA_W = $clog2(COOLDOWN + 1);

    estado_t              r_estado;
    logic [PASSO_W-1:0]   r_passo;
    logic [RECARGA_W-1:0] r_recarga;
    logic [10:0]          r_x;
    logic [10:0]          r_y;
    logic                 r_tiro_ativo;
    logic                 r_acerto;
    logic [7:0]           r_r;
    logic [7:0]           r_g;
    logic [7:0]           r_b;

    logic        w_disparo;
    logic [10:0] w_x_lim_ini;
    logic [10:0] w_y_lim_ini;
    logic [10:0] w_x_fim;
    logic [10:0] w_y_fim;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_hit;
    logic        w_tick;
    logic        w_fim_recarga;
    logic        w_pixel_tiro;

    detector_borda u_borda (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_sinal (btn_fire),
        .o_pulso (w_disparo)
    );

    // All bounds are 11-bit unsigned and wrap like the hardware adders would.
    assign w_x_lim_ini = posX_inimigo + 11'(LARGURA_INIMIGO);
    assign w_y_lim_ini = posY_inimigo + 11'(ALTURA_INIMIGO);
    assign w_x_fim     = r_x + 11'(TIRO_W);
    assign w_y_fim     = r_y + 11'(TIRO_H);
    assign w_h         = {1'b0, h_counter};
    assign w_v         = {1'b0, v_counter};

    assign w_hit = (posX_inimigo <= r_x) && (r_x < w_x_lim_ini) &&
                   (posY_inimigo <= r_y) && (r_y < w_y_lim_ini);
    assign w_tick        = (r_passo == PASSO_W'(DELAY_MOVIMENTO - 1));
    assign w_fim_recarga = (r_recarga == RECARGA_W'(COOLDOWN - 1));
    assign w_pixel_tiro  = r_tiro_ativo &&
                           (r_x <= w_h) && (w_h < w_x_fim) &&
                           (r_y <= w_v) && (w_v < w_y_fim);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado     <= OCIOSO;
            r_passo      <= '0;
            r_recarga    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_tiro_ativo <= 1'b0;
            r_acerto     <= 1'b0;
        end else begin
            r_acerto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_disparo) begin
                        r_x          <= posX_jogador;
                        r_y          <= posY_jogador;
                        r_passo      <= '0;
                        r_tiro_ativo <= 1'b1;
                        r_estado     <= VOO;
                    end
                end
                VOO: begin
                    // A hit wins over a step tick landing on the same cycle.
                    if (w_hit) begin
                        r_acerto     <= 1'b1;
                        r_tiro_ativo <= 1'b0;
                        r_recarga    <= '0;
                        r_estado     <= RECARGA;
                    end else if (w_tick) begin
                        r_passo <= '0;
                        if (r_y <= 11'(Y_TOPO)) begin
                            r_tiro_ativo <= 1'b0;
                            r_recarga    <= '0;
                            r_estado     <= RECARGA;
                        end else begin
                            r_y <= r_y - 11'd1;
                        end
                    end else begin
                        r_passo <= r_passo + PASSO_W'(1);
                    end
                end
                RECARGA: begin
                    if (w_fim_recarga) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_recarga <= r_recarga + RECARGA_W'(1);
                    end
                end
                default: begin
                    r_tiro_ativo <= 1'b0;
                    r_estado     <= OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_r <= COR_NULA;
            r_g <= COR_NULA;
            r_b <= COR_NULA;
        end else begin
            r_r <= COR_NULA;
            r_b <= COR_NULA;
            if ((w_v <= 11'(V_MIN)) || (w_h <= 11'(H_MIN))) begin
                r_g <= COR_NULA;
            end else if (w_pixel_tiro) begin
                r_g <= COR_CHEIA;
            end else begin
                r_g <= COR_NULA;
            end
        end
    end

    assign posX_Municao1 = r_x;
    assign posY_Municao1 = r_y;
    assign tiro_ativo    = r_tiro_ativo;
    assign acerto        = r_acerto;
    assign R             = r_r;
    assign G             = r_g;
    assign B             = r_b;

endmodule

// File: tb/tb_municao_jogador.sv
// Directed bench for municao_jogador: render tables plus hand-written
// sequences for launch, hit, miss, ignored presses and async reset.
module tb_municao_jogador;

    logic        clk;
    logic        reset;
    logic        btn_fire;
    logic [10:0] posX_jogador;
    logic [10:0] posY_jogador;
    logic [10:0] posX_inimigo;
    logic [10:0] posY_inimigo;
    logic [9:0]  h_counter;
    logic [9:0]  v_counter;
    logic [10:0] posX_Municao1;
    logic [10:0] posY_Municao1;
    logic        tiro_ativo;
    logic        acerto;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acerto = 0;

    municao_jogador #(
        .DELAY_MOVIMENTO (4),
        .COOLDOWN        (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_fire      (btn_fire),
        .posX_jogador  (posX_jogador),
        .posY_jogador  (posY_jogador),
        .posX_inimigo  (posX_inimigo),
        .posY_inimigo  (posY_inimigo),
        .h_counter     (h_counter),
        .v_counter     (v_counter),
        .posX_Municao1 (posX_Municao1),
        .posY_Municao1 (posY_Municao1),
        .tiro_ativo    (tiro_ativo),
        .acerto        (acerto),
        .R             (R),
        .G             (G),
        .B             (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (acerto === 1'b1) n_acerto = n_acerto + 1;
    end

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [23:0] rgb;
    } vec_t;

    vec_t tab_a[10];
    vec_t tab_b[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Press (optionally hold) the button, wait for tiro_ativo, check latency and launch position.
    task automatic launch(input logic [10:0] x, input logic [10:0] y, input bit hold);
        int lat;
        posX_jogador = x;
        posY_jogador = y;
        btn_fire = 1'b1;
        @(negedge clk);
        if (!hold) btn_fire = 1'b0;
        lat = 1;
        while (tiro_ativo !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat = lat + 1;
        end
        check("launch_latency", 32'(lat), 32'd4);
        check("launch_x", 32'(posX_Municao1), 32'(x));
        check("launch_y", 32'(posY_Municao1), 32'(y));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        btn_fire = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_table_a();
        for (int i = 0; i < 10; i++) begin
            h_counter = tab_a[i].h;
            v_counter = tab_a[i].v;
            @(negedge clk);
            check($sformatf("render_a[%0d]", i), 32'({R, G, B}), 32'(tab_a[i].rgb));
        end
    endtask

    task automatic run_table_b();
        for (int i = 0; i < 4; i++) begin
            h_counter = tab_b[i].h;
            v_counter = tab_b[i].v;
            @(negedge clk);
            check($sformatf("render_b[%0d]", i), 32'({R, G, B}), 32'(tab_b[i].rgb));
        end
    endtask

    initial begin
        int ac0;
        bit saw;

        // Shot at X=300; Y=200 for rows 0..3, 199 for rows 4..7, 198 for rows 8..9.
        tab_a[0] = '{h: 10'd301, v: 10'd219, rgb: 24'h00FF00};
        tab_a[1] = '{h: 10'd302, v: 10'd219, rgb: 24'h000000};
        tab_a[2] = '{h: 10'd301, v: 10'd220, rgb: 24'h000000};
        tab_a[3] = '{h: 10'd90,  v: 10'd210, rgb: 24'h000000};
        tab_a[4] = '{h: 10'd300, v: 10'd199, rgb: 24'h00FF00};
        tab_a[5] = '{h: 10'd300, v: 10'd218, rgb: 24'h00FF00};
        tab_a[6] = '{h: 10'd300, v: 10'd198, rgb: 24'h000000};
        tab_a[7] = '{h: 10'd299, v: 10'd210, rgb: 24'h000000};
        tab_a[8] = '{h: 10'd301, v: 10'd198, rgb: 24'h00FF00};
        tab_a[9] = '{h: 10'd301, v: 10'd2,   rgb: 24'h000000};
        // Shot at (96,2): straddles both blanking limits.
        tab_b[0] = '{h: 10'd97, v: 10'd3, rgb: 24'h00FF00};
        tab_b[1] = '{h: 10'd96, v: 10'd3, rgb: 24'h000000};
        tab_b[2] = '{h: 10'd97, v: 10'd2, rgb: 24'h000000};
        tab_b[3] = '{h: 10'd98, v: 10'd3, rgb: 24'h000000};

        reset = 1'b0;
        btn_fire = 1'b0;
        posX_jogador = '0;
        posY_jogador = '0;
        posX_inimigo = '0;
        posY_inimigo = '0;
        h_counter = '0;
        v_counter = '0;
        repeat (3) @(negedge clk);
        check("rst_tiro", 32'(tiro_ativo), 32'd0);
        check("rst_acerto", 32'(acerto), 32'd0);
        check("rst_x", 32'(posX_Municao1), 32'd0);
        check("rst_y", 32'(posY_Municao1), 32'd0);
        check("rst_rgb", 32'({R, G, B}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Fire and climb, X frozen, then async reset mid-flight.
        launch(11'd300, 11'd400, 1'b0);
        repeat (4) @(negedge clk);
        check("fire_y_399", 32'(posY_Municao1), 32'd399);
        posX_jogador = 11'd500;
        repeat (4) @(negedge clk);
        check("fire_y_398", 32'(posY_Municao1), 32'd398);
        check("fire_x_frozen", 32'(posX_Municao1), 32'd300);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_tiro", 32'(tiro_ativo), 32'd0);
        check("areset_x", 32'(posX_Municao1), 32'd0);
        check("areset_y", 32'(posY_Municao1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("areset_idle", 32'(tiro_ativo), 32'd0);
        check("areset_no_acerto", 32'(n_acerto), 32'd0);

        // Hit on the first flight cycle, button held across the return to idle.
        posX_inimigo = 11'd290;
        posY_inimigo = 11'd380;
        ac0 = n_acerto;
        launch(11'd300, 11'd400, 1'b1);
        check("hit_acerto_pre", 32'(acerto), 32'd0);
        @(negedge clk);
        check("hit_acerto", 32'(acerto), 32'd1);
        check("hit_tiro_off", 32'(tiro_ativo), 32'd0);
        @(negedge clk);
        check("hit_acerto_once", 32'(acerto), 32'd0);
        check("hit_pulse_count", 32'(n_acerto - ac0), 32'd1);
        check("hit_x_hold", 32'(posX_Municao1), 32'd300);
        check("hit_y_hold", 32'(posY_Municao1), 32'd400);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tiro_ativo !== 1'b0) saw = 1'b1;
        end
        check("held_no_relaunch", 32'(saw), 32'd0);
        btn_fire = 1'b0;
        repeat (3) @(negedge clk);

        // Miss at the top, presses during flight and cooldown ignored.
        posX_inimigo = 11'd1000;
        posY_inimigo = 11'd1000;
        ac0 = n_acerto;
        launch(11'd300, 11'd5, 1'b0);
        posX_jogador = 11'd700;
        posY_jogador = 11'd100;
        btn_fire = 1'b1;
        @(negedge clk);
        btn_fire = 1'b0;
        repeat (7) @(negedge clk);
        check("miss_y_3", 32'(posY_Municao1), 32'd3);
        check("miss_x_frozen", 32'(posX_Municao1), 32'd300);
        check("miss_still_flying", 32'(tiro_ativo), 32'd1);
        repeat (4) @(negedge clk);
        check("miss_tiro_off", 32'(tiro_ativo), 32'd0);
        check("miss_y_hold", 32'(posY_Municao1), 32'd3);
        check("miss_no_acerto", 32'(n_acerto - ac0), 32'd0);
        btn_fire = 1'b1;
        @(negedge clk);
        btn_fire = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (tiro_ativo !== 1'b0) saw = 1'b1;
        end
        check("cooldown_ignored", 32'(saw), 32'd0);
        launch(11'd300, 11'd50, 1'b0);
        do_reset();

        // Render checks.
        launch(11'd300, 11'd200, 1'b0);
        run_table_a();
        h_counter = '0;
        v_counter = '0;
        do_reset();
        ac0 = n_acerto;
        launch(11'd96, 11'd2, 1'b0);
        run_table_b();
        check("top_launch_miss", 32'(tiro_ativo), 32'd0);
        check("top_launch_y", 32'(posY_Municao1), 32'd2);
        check("top_launch_no_acerto", 32'(n_acerto - ac0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
